// File: rtl/prog_loader_pkg.sv
// Shared types and defaults for the byte-stream program loader.
// Latency: n/a. Backpressure: n/a.
package prog_loader_pkg;

    localparam int         PROG_ADDR_W   = 13;
    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR_H,
        ST_ADDR_L,
        ST_CNT_H,
        ST_CNT_L,
        ST_DATA_H,
        ST_DATA_L,
        ST_WRITE,
        ST_CSUM,
        ST_DONE
    } loader_state_t;

endpackage

// File: rtl/loader_csum.sv
// 8-bit running checksum with clear, add-on-strobe and zero-check of sum plus current byte.
// Latency: accumulator updates one cycle after add; zero-check is combinational. Backpressure: none.
module loader_csum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       add,
    input  logic [7:0] din,
    output logic       zero_with_din
);

    logic [7:0] acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= 8'h00;
        end else if (clr) begin
            acc_q <= 8'h00;
        end else if (add) begin
            acc_q <= acc_q + din;
        end
    end

    assign zero_with_din = ((acc_q + din) == 8'h00);

endmodule

// File: rtl/prog_loader.sv
// Framed byte stream -> 16-bit word writes into split high/low program RAMs; LOADER_CHECKSUM_EN adds trailing CSUM check.
// Latency: one write per two accepted data bytes plus one stall cycle.
// Backpressure: rx_ready low during WRITE and DONE; rx_valid gaps wait indefinitely.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         ADDR_W    = PROG_ADDR_W,
    parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data_h,
    output logic [7:0]        wr_data_l,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int HI_W = ADDR_W - 8;

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t END_ST = ST_CSUM;
`else
    localparam loader_state_t END_ST = ST_DONE;
`endif

    loader_state_t     state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_full;
    logic              xfer;
    logic              sync_acc;

    assign rx_ready = !rst && (state != ST_WRITE) && (state != ST_DONE);
    assign xfer     = rx_valid && rx_ready;
    assign sync_acc = (state == ST_IDLE) && xfer && (rx_data == SYNC_BYTE);
    assign cnt_full = {cnt_q[ADDR_W-1:8], rx_data};

    assign wr_en    = (state == ST_WRITE);
    assign done     = (state == ST_DONE);
    assign cpu_hold = (state != ST_IDLE) && (state != ST_DONE);
    assign wr_addr  = addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (sync_acc) state_nxt = ST_ADDR_H;
            ST_ADDR_H: if (xfer)     state_nxt = ST_ADDR_L;
            ST_ADDR_L: if (xfer)     state_nxt = ST_CNT_H;
            ST_CNT_H:  if (xfer)     state_nxt = ST_CNT_L;
            ST_CNT_L:  if (xfer)     state_nxt = (cnt_full == '0) ? END_ST : ST_DATA_H;
            ST_DATA_H: if (xfer)     state_nxt = ST_DATA_L;
            ST_DATA_L: if (xfer)     state_nxt = ST_WRITE;
            ST_WRITE:                state_nxt = (cnt_q == ADDR_W'(1)) ? END_ST : ST_DATA_H;
            ST_CSUM:   if (xfer)     state_nxt = ST_DONE;
            ST_DONE:                 state_nxt = ST_IDLE;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    // Only the low HI_W bits of ADDR_H/CNT_H are meaningful.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            cnt_q     <= '0;
            wr_data_h <= 8'h00;
            wr_data_l <= 8'h00;
        end else begin
            case (state)
                ST_ADDR_H: if (xfer) addr_q[ADDR_W-1:8] <= rx_data[HI_W-1:0];
                ST_ADDR_L: if (xfer) addr_q[7:0]        <= rx_data;
                ST_CNT_H:  if (xfer) cnt_q[ADDR_W-1:8]  <= rx_data[HI_W-1:0];
                ST_CNT_L:  if (xfer) cnt_q[7:0]         <= rx_data;
                ST_DATA_H: if (xfer) wr_data_h          <= rx_data;
                ST_DATA_L: if (xfer) wr_data_l          <= rx_data;
                ST_WRITE: begin
                    addr_q <= addr_q + ADDR_W'(1);
                    cnt_q  <= cnt_q - ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic csum_ok;
    logic err_q;

    loader_csum u_csum (
        .clk           (clk),
        .rst           (rst),
        .clr           (sync_acc),
        .add           (xfer && (state != ST_IDLE)),
        .din           (rx_data),
        .zero_with_din (csum_ok)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (sync_acc) begin
            err_q <= 1'b0;
        end else if ((state == ST_CSUM) && xfer && !csum_ok) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a write scoreboard; build with LOADER_CHECKSUM_EN to exercise CSUM.
`timescale 1ns/1ps
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        wr_en;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data_h;
    logic [7:0]  wr_data_l;
    logic        cpu_hold;
    logic        done;
    logic        err;

    prog_loader dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data_h (wr_data_h),
        .wr_data_l (wr_data_l),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          done_exp = 0;
    logic [28:0] exp_q[$];
    logic [7:0]  payload[$];
    logic [28:0] mon_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Write monitor: every wr_en must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && (wr_en || done)) begin
            check("done_wr_exclusive", {31'b0, wr_en & done}, 32'd0);
            if (done) done_cnt++;
            if (wr_en) begin
                check("hold_during_wr", {31'b0, cpu_hold}, 32'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_wr", {19'b0, wr_addr}, 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr",   {19'b0, wr_addr},   {19'b0, mon_e[28:16]});
                    check("wr_data_h", {24'b0, wr_data_h}, {24'b0, mon_e[15:8]});
                    check("wr_data_l", {24'b0, wr_data_l}, {24'b0, mon_e[7:0]});
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 50) check("rx_ready_timeout", {31'b0, rx_ready}, 32'd1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [12:0] addr, input logic bad_csum);
        logic [7:0]  hdr[4];
        logic [7:0]  sum;
        logic [12:0] a;
        int          cnt;
        cnt    = payload.size() / 2;
        hdr[0] = {3'b0, addr[12:8]};
        hdr[1] = addr[7:0];
        hdr[2] = 8'(cnt >> 8);
        hdr[3] = 8'(cnt);
        sum    = 8'h00;
        a      = addr;
        check("hold_before_sync", {31'b0, cpu_hold}, 32'd0);
        send_byte(8'hA5);
        check("hold_after_sync", {31'b0, cpu_hold}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            send_byte(hdr[i]);
            sum = sum + hdr[i];
        end
        for (int i = 0; i < cnt; i++) begin
            send_byte(payload[2*i]);
            exp_q.push_back({a, payload[2*i], payload[2*i+1]});
            send_byte(payload[2*i+1]);
            sum = sum + payload[2*i] + payload[2*i+1];
            a = a + 13'd1;
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'(8'h00 - sum) + {7'b0, bad_csum});
`else
        if (bad_csum) sum = 8'h00;
`endif
    endtask

    task automatic wait_done(input logic exp_err);
        int n;
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        done_exp++;
        check("done_seen",    {31'b0, done},     32'd1);
        check("hold_at_done", {31'b0, cpu_hold}, 32'd0);
        check("rdy_at_done",  {31'b0, rx_ready}, 32'd0);
        check("err_at_done",  {31'b0, err},      {31'b0, exp_err});
        @(posedge clk); #1;
        check("done_one_cycle", {31'b0, done},     32'd0);
        check("hold_after",     {31'b0, cpu_hold}, 32'd0);
        check("done_count",     done_cnt,          done_exp);
        check("sb_empty",       exp_q.size(),      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst_rx_ready",  {31'b0, rx_ready},  32'd0);
        check("rst_wr_en",     {31'b0, wr_en},     32'd0);
        check("rst_cpu_hold",  {31'b0, cpu_hold},  32'd0);
        check("rst_done",      {31'b0, done},      32'd0);
        check("rst_err",       {31'b0, err},       32'd0);
        check("rst_wr_addr",   {19'b0, wr_addr},   32'd0);
        check("rst_wr_data_h", {24'b0, wr_data_h}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rdy_after_rst", {31'b0, rx_ready}, 32'd1);

        // Basic two-word frame at 0x010
        payload = '{8'h12, 8'h34, 8'h56, 8'h78};
        send_frame(13'h010, 1'b0);
        wait_done(1'b0);

        // Count-zero frame: no writes
        payload = {};
        send_frame(13'h1FFF, 1'b0);
        wait_done(1'b0);

        // Address wrap 0x1FFF -> 0x0000
        payload = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_frame(13'h1FFF, 1'b0);
        wait_done(1'b0);

        // Garbage before sync is discarded
        send_byte(8'h00);
        check("garbage_hold0", {31'b0, cpu_hold}, 32'd0);
        send_byte(8'hFF);
        check("garbage_hold1", {31'b0, cpu_hold}, 32'd0);
        send_byte(8'h5A);
        check("garbage_hold2", {31'b0, cpu_hold}, 32'd0);
        payload = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_frame(13'h0ABC, 1'b0);
        wait_done(1'b0);

        // Reset after first data byte drops the frame
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h20);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h11);
        rst = 1'b1;
        #1;
        check("midrst_wr_en",    {31'b0, wr_en},     32'd0);
        check("midrst_hold",     {31'b0, cpu_hold},  32'd0);
        check("midrst_rdy",      {31'b0, rx_ready},  32'd0);
        check("midrst_done",     {31'b0, done},      32'd0);
        check("midrst_wr_addr",  {19'b0, wr_addr},   32'd0);
        check("midrst_wr_dat_h", {24'b0, wr_data_h}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        payload = '{8'h9A, 8'hBC};
        send_frame(13'h0020, 1'b0);
        wait_done(1'b0);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum sets err at done; next sync clears it
        payload = '{8'h11, 8'h22};
        send_frame(13'h0100, 1'b1);
        wait_done(1'b1);
        check("err_sticky", {31'b0, err}, 32'd1);
        send_byte(8'hA5);
        check("err_clr_sync", {31'b0, err}, 32'd0);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_done(1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
